ram_port_arbiter: RTL and testbench

//  Shares the single-port data_ram between the pipeline CPU data port and a DMA/loader port.

---
 rtl/ram_port_arbiter_pkg.sv | 17 +
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the data_ram port arbiter: arbitration states and a counter-width helper.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'b00,
    S_LOCK  = 2'b01,
    S_YIELD = 2'b10
  } arb_state_e;

  localparam int SEL_W = 4;

  // Bits needed to hold a counter value in [0, max_val]; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data_ram between the CPU data port and a DMA/loader port:
// fixed CPU priority, a starvation guard for DMA, and a bounded DMA burst lock.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_lock_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [SEL_W-1:0]  dma_sel_i,
  input  logic [DATA_W-1:0] dma_data_i,
  output logic [DATA_W-1:0] dma_data_o,
  output logic              dma_ack_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int STARVE_W = cnt_width(STARVE_LIMIT);
  localparam int LOCK_W   = cnt_width(MAX_LOCK - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0]   LOCK_LAST  = LOCK_W'(MAX_LOCK - 1);
  localparam logic [LOCK_W-1:0]   LOCK_FIRST = LOCK_W'(1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;

  logic cpu_req;
  logic grant_dma;
  logic cpu_served;

  // Reset also gates the request/grant path so ack, stall and ram_ce_o drop without a clock edge.
  assign cpu_req = cpu_ce_i & rst;

  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    grant_dma = 1'b0;
    case (state_q)
      S_CPU:   grant_dma = dma_req_i & (~cpu_ce_i | (starve_cnt_q == STARVE_MAX));
      S_LOCK:  grant_dma = dma_req_i;
      S_YIELD: grant_dma = dma_req_i & ~cpu_ce_i;
      default: grant_dma = 1'b0;
    endcase
    grant_dma = grant_dma & rst;
  end

  assign cpu_served  = cpu_req & ~grant_dma;
  assign dma_ack_o   = grant_dma;
  assign cpu_stall_o = cpu_req & grant_dma;
  assign cpu_data_o  = cpu_served ? ram_data_i : '0;
  assign dma_data_o  = grant_dma  ? ram_data_i : '0;

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (grant_dma) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = dma_we_i;
      ram_addr_o = dma_addr_i;
      ram_sel_o  = dma_sel_i;
      ram_data_o = dma_data_i;
    end else if (cpu_req) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = cpu_we_i;
      ram_addr_o = cpu_addr_i;
      ram_sel_o  = cpu_sel_i;
      ram_data_o = cpu_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      S_CPU: begin
        if (grant_dma || !dma_req_i) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
        if (grant_dma && dma_lock_i) begin
          state_d    = S_LOCK;
          lock_cnt_d = LOCK_FIRST;
        end
      end
      S_LOCK: begin
        // Inside a burst the DMA is always granted while requesting, so ack == dma_req_i here.
        if (!dma_req_i || !dma_lock_i) begin
          state_d    = S_CPU;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = S_YIELD;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      S_YIELD: begin
        state_d      = S_CPU;
        starve_cnt_d = '0;
      end
      default: begin
        state_d      = S_CPU;
        starve_cnt_d = '0;
        lock_cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments and an asynchronous reset to a known idle state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CPU;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural arbitration/memory model.
module tb_ram_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_LOCK     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_ce_i, cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [3:0]        cpu_sel_i;
  logic [DATA_W-1:0] cpu_data_i, cpu_data_o;
  logic              cpu_stall_o;
  logic              dma_req_i, dma_lock_i, dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [3:0]        dma_sel_i;
  logic [DATA_W-1:0] dma_data_i, dma_data_o;
  logic              dma_ack_o;
  logic              ram_ce_o, ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [3:0]        ram_sel_o;
  logic [DATA_W-1:0] ram_data_o, ram_data_i;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_sel_i(cpu_sel_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_lock_i(dma_lock_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_sel_i(dma_sel_i), .dma_data_i(dma_data_i), .dma_data_o(dma_data_o), .dma_ack_o(dma_ack_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    for (int b = 0; b < 4; b++) if (sel[b]) old[8*b +: 8] = wd[8*b +: 8];
    return old;
  endfunction

  // data_ram stand-in driven by the DUT's RAM port: async read, byte-enabled write on clk.
  logic [31:0] ram_mem [16] = '{default: '0};
  assign ram_data_i = ram_mem[ram_addr_o[5:2]];
  always @(posedge clk)
    if (ram_ce_o && ram_we_o)
      ram_mem[ram_addr_o[5:2]] <= merge(ram_mem[ram_addr_o[5:2]], ram_data_o, ram_sel_o);

  // Behavioural model: how long the DMA has been waiting, how many beats of the current
  // locked burst are done, and whether the CPU is owed its yield turn.
  int          denied_run  = 0;
  int          burst_beats = 0;
  bit          yield_turn  = 1'b0;
  logic [31:0] ref_mem [16] = '{default: '0};

  function automatic bit model_dma_wins();
    if (!dma_req_i)      return 1'b0;
    if (burst_beats > 0) return 1'b1;
    if (yield_turn)      return !cpu_ce_i;
    return !cpu_ce_i || (denied_run >= STARVE_LIMIT);
  endfunction

  always @(posedge clk) begin
    bit win;
    if (rst) begin
      win = model_dma_wins();
      if (win && dma_we_i)
        ref_mem[dma_addr_i[5:2]] = merge(ref_mem[dma_addr_i[5:2]], dma_data_i, dma_sel_i);
      else if (!win && cpu_ce_i && cpu_we_i)
        ref_mem[cpu_addr_i[5:2]] = merge(ref_mem[cpu_addr_i[5:2]], cpu_data_i, cpu_sel_i);
      if (yield_turn) begin
        yield_turn = 1'b0;
        denied_run = 0;
      end else if (burst_beats > 0) begin
        if (!dma_req_i || !dma_lock_i) burst_beats = 0;
        else if (burst_beats + 1 == MAX_LOCK) begin
          burst_beats = 0;
          yield_turn  = 1'b1;
        end else burst_beats++;
      end else if (win) begin
        denied_run = 0;
        if (dma_lock_i) burst_beats = 1;
      end else if (dma_req_i) denied_run++;
      else denied_run = 0;
    end
  end

  always @(negedge rst) begin
    denied_run  = 0;
    burst_beats = 0;
    yield_turn  = 1'b0;
  end

  // Single compare process: every cycle, mid-period, all outputs against the model.
  bit exp_ack, exp_stall, cpu_srv;
  always @(negedge clk) begin
    logic              e_ce, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [3:0]        e_sel;
    logic [DATA_W-1:0] e_data;
    exp_ack   = rst && model_dma_wins();
    exp_stall = rst && cpu_ce_i && exp_ack;
    cpu_srv   = rst && cpu_ce_i && !exp_ack;
    {e_ce, e_we, e_addr, e_sel, e_data} = '0;
    if (exp_ack) {e_ce, e_we, e_addr, e_sel, e_data} = {1'b1, dma_we_i, dma_addr_i, dma_sel_i, dma_data_i};
    else if (cpu_srv) {e_ce, e_we, e_addr, e_sel, e_data} = {1'b1, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i};
    check("dma_ack", dma_ack_o, exp_ack);
    check("cpu_stall", cpu_stall_o, exp_stall);
    check("ram_ce", ram_ce_o, e_ce);
    check("ram_we", ram_we_o, e_we);
    check("ram_addr", ram_addr_o, e_addr);
    check("ram_sel", ram_sel_o, e_sel);
    check("ram_wdata", ram_data_o, e_data);
    check("cpu_rdata", cpu_data_o, cpu_srv ? ref_mem[cpu_addr_i[5:2]] : 32'h0);
    check("dma_rdata", dma_data_o, exp_ack ? ref_mem[dma_addr_i[5:2]] : 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    dma_req_i = 1'b0; dma_lock_i = 1'b0; dma_we_i = 1'b0; dma_addr_i = '0; dma_sel_i = '0;
    dma_data_i = '0;
  endtask

  task automatic cpu_set(input logic we, input logic [31:0] addr, input logic [31:0] data);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = 4'hF; cpu_data_i = data;
  endtask

  task automatic dma_set(input logic lock, input logic we, input logic [31:0] addr,
                         input logic [31:0] data);
    dma_req_i = 1'b1; dma_lock_i = lock; dma_we_i = we; dma_addr_i = addr; dma_sel_i = 4'hF;
    dma_data_i = data;
  endtask

  task automatic drive_random(input int cpu_rate);
    logic [3:0] idx;
    if (!(dma_req_i && !exp_ack)) begin
      idx        = 4'($urandom_range(0, 15));
      dma_req_i  = ($urandom_range(0, 3) != 0);
      dma_lock_i = ($urandom_range(0, 7) != 0);
      dma_we_i   = $urandom_range(0, 1);
      dma_addr_i = {26'b0, idx, 2'b00};
      dma_sel_i  = 4'($urandom_range(0, 15));
      dma_data_i = $urandom;
    end
    if (!(cpu_ce_i && exp_stall)) begin
      idx        = 4'($urandom_range(0, 15));
      cpu_ce_i   = ($urandom_range(0, 9) < cpu_rate);
      cpu_we_i   = $urandom_range(0, 1);
      cpu_addr_i = {26'b0, idx, 2'b00};
      cpu_sel_i  = 4'($urandom_range(0, 15));
      cpu_data_i = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int acks;
    idle();
    // Reset held with both masters requesting: nothing may be granted or driven.
    cpu_set(1'b1, 32'h10, 32'h1111_1111);
    dma_set(1'b1, 1'b1, 32'h20, 32'h2222_2222);
    sample();
    check("reset_ack", dma_ack_o, 1'b0);
    check("reset_stall", cpu_stall_o, 1'b0);
    check("reset_ram_ce", ram_ce_o, 1'b0);
    tick();
    rst = 1'b1;
    idle();

    // CPU alone: write then read back.
    cpu_set(1'b1, 32'h10, 32'hDEAD_BEEF);
    sample();
    check("t1_we", ram_we_o, 1'b1);
    check("t1_stall", cpu_stall_o, 1'b0);
    tick();
    cpu_set(1'b0, 32'h10, 32'h0);
    sample();
    check("t1_readback", cpu_data_o, 32'hDEAD_BEEF);
    tick();

    // DMA alone without lock: acked every cycle, arbiter stays in CPU-priority mode.
    idle();
    dma_set(1'b0, 1'b0, 32'h20, 32'h0);
    repeat (3) begin
      sample();
      check("t2_ack", dma_ack_o, 1'b1);
      tick();
    end
    cpu_set(1'b0, 32'h10, 32'h0);
    sample();
    check("t2_cpu_prio", dma_ack_o, 1'b0);
    check("t2_cpu_data", cpu_data_o, 32'hDEAD_BEEF);
    tick();
    idle();
    sample();
    tick();

    // Contention: four denied cycles, fifth preempts the CPU, then the guard re-arms.
    cpu_set(1'b0, 32'h10, 32'h0);
    dma_set(1'b0, 1'b0, 32'h20, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      sample();
      check($sformatf("t3_ack_c%0d", c), dma_ack_o, c == 5);
      check($sformatf("t3_stall_c%0d", c), cpu_stall_o, c == 5);
      tick();
    end
    idle();
    sample();
    tick();

    // Locked burst of 12 against a busy CPU: 8 beats, one yield cycle, then starvation again.
    cpu_set(1'b0, 32'h10, 32'h0);
    dma_set(1'b1, 1'b1, 32'h24, 32'hCAFE_0000);
    acks = 0;
    for (int c = 1; c <= 18; c++) begin
      sample();
      if (c <= 13) acks += int'(dma_ack_o);
      check($sformatf("t4_ack_c%0d", c), dma_ack_o, (c >= 5 && c <= 12) || c == 18);
      if (c == 13) check("t4_yield_stall", cpu_stall_o, 1'b0);
      tick();
    end
    check("t4_burst_beats", acks, 8);
    idle();
    sample();
    tick();

    // Lock dropped on beat 3: back to CPU priority on the very next cycle.
    dma_set(1'b1, 1'b0, 32'h28, 32'h0);
    sample();
    tick();
    sample();
    tick();
    dma_lock_i = 1'b0;
    sample();
    check("t5_beat3_ack", dma_ack_o, 1'b1);
    tick();
    cpu_set(1'b0, 32'h10, 32'h0);
    sample();
    check("t5_cpu_wins", dma_ack_o, 1'b0);
    check("t5_no_stall", cpu_stall_o, 1'b0);
    tick();
    idle();
    sample();
    tick();

    // Reset asserted between edges during beat 5 of a burst.
    cpu_set(1'b0, 32'h10, 32'h0);
    dma_set(1'b1, 1'b0, 32'h2C, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      sample();
      tick();
    end
    check("t6_beat5_ack", dma_ack_o, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_async_ack", dma_ack_o, 1'b0);
    check("t6_async_stall", cpu_stall_o, 1'b0);
    check("t6_async_ram_ce", ram_ce_o, 1'b0);
    tick();
    rst = 1'b1;
    sample();
    check("t6_after_ack", dma_ack_o, 1'b0);
    check("t6_after_stall", cpu_stall_o, 1'b0);
    tick();
    idle();
    sample();
    tick();

    // Randomized traffic under varying CPU load.
    for (int n = 0; n < 3000; n++) begin
      drive_random((n / 500) % 2 == 0 ? 9 : 4);
      sample();
      tick();
    end
    idle();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
